// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, zero-register constant and write-source encoding
package wb_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_SKID,
    SRC_ALU
  } wb_src_e;
endpackage

// File: rtl/wb_load_queue.sv
// rtl/wb_load_queue.sv - in-order FIFO of pending load destinations with parallel
// two-index lookup against the entries still outstanding
module wb_load_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [AW-1:0]          push_rd,
  input  logic                   pop,
  output logic [AW-1:0]          head_rd,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic [AW-1:0]          q_a,
  input  logic [AW-1:0]          q_b,
  output logic                   match_a,
  output logic                   match_b
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_rd = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_rd;
  end

  // A push and a pop never target the same slot: push needs !full, pop needs !empty.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && mem[i] == q_a) match_a = 1'b1;
      if (valid[i] && mem[i] == q_b) match_b = 1'b1;
    end
  end
endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - merges ALU results and load returns onto the regfile
// write port; load returns never stall, so a colliding ALU result parks in a skid
module writeback_stage #(
  parameter int LQ_DEPTH = 4,
  parameter int REG_AW   = wb_pkg::REG_AW,
  parameter int DATA_W   = wb_pkg::DATA_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [REG_AW-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  output logic                      alu_ready,
  input  logic                      ld_issue,
  input  logic [REG_AW-1:0]         ld_rd,
  output logic                      ld_issue_ready,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic [REG_AW-1:0]         chk_rs,
  input  logic [REG_AW-1:0]         chk_rt,
  output logic                      hazard,
  output logic                      regWrite,
  output logic [REG_AW-1:0]         rd,
  output logic [DATA_W-1:0]         data,
  output logic [$clog2(LQ_DEPTH):0] pending_cnt,
  output logic                      wb_err
);
  import wb_pkg::*;

  logic              q_full;
  logic              q_empty;
  logic [REG_AW-1:0] q_head;
  logic              match_rs;
  logic              match_rt;
  logic              skid_valid;
  logic [REG_AW-1:0] skid_rd;
  logic [DATA_W-1:0] skid_data;
  logic              load_fire;
  logic              alu_fire;
  wb_src_e           src;
  logic [REG_AW-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic              hz_rs;
  logic              hz_rt;

  assign alu_ready      = !skid_valid;
  assign ld_issue_ready = !q_full;
  assign load_fire      = mem_rvalid && !q_empty;
  assign alu_fire       = alu_valid && alu_ready;

  wb_load_queue #(.DEPTH(LQ_DEPTH), .AW(REG_AW)) u_lq (
    .clock   (clock),
    .reset   (reset),
    .push    (ld_issue && ld_issue_ready),
    .push_rd (ld_rd),
    .pop     (load_fire),
    .head_rd (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (pending_cnt),
    .q_a     (chk_rs),
    .q_b     (chk_rt),
    .match_a (match_rs),
    .match_b (match_rt)
  );

  always_comb begin
    src     = SRC_NONE;
    wr_rd   = '0;
    wr_data = '0;
    if (load_fire) begin
      src     = SRC_LOAD;
      wr_rd   = q_head;
      wr_data = mem_rdata;
    end else if (skid_valid) begin
      src     = SRC_SKID;
      wr_rd   = skid_rd;
      wr_data = skid_data;
    end else if (alu_fire) begin
      src     = SRC_ALU;
      wr_rd   = alu_rd;
      wr_data = alu_data;
    end
  end

  // Writes to register 0 still consume their slot but never strobe the regfile.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regWrite   <= 1'b0;
      rd         <= '0;
      data       <= '0;
      skid_valid <= 1'b0;
      skid_rd    <= '0;
      skid_data  <= '0;
      wb_err     <= 1'b0;
    end else begin
      if (src != SRC_NONE && wr_rd != REG_AW'(ZERO_REG)) begin
        regWrite <= 1'b1;
        rd       <= wr_rd;
        data     <= wr_data;
      end else begin
        regWrite <= 1'b0;
      end
      if (alu_fire && load_fire) begin
        skid_valid <= 1'b1;
        skid_rd    <= alu_rd;
        skid_data  <= alu_data;
      end else if (src == SRC_SKID) begin
        skid_valid <= 1'b0;
      end
      if (mem_rvalid && q_empty) wb_err <= 1'b1;
    end
  end

  assign hz_rs  = (chk_rs != REG_AW'(ZERO_REG)) && (match_rs || (regWrite && rd == chk_rs));
  assign hz_rt  = (chk_rt != REG_AW'(ZERO_REG)) && (match_rt || (regWrite && rd == chk_rt));
  assign hazard = hz_rs || hz_rt;
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed vector table plus reset/error sequence
module tb_writeback_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_issue_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic        hazard;
  logic        regWrite;
  logic [4:0]  rd;
  logic [31:0] data;
  logic [2:0]  pending_cnt;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.LQ_DEPTH(4), .REG_AW(5), .DATA_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .ld_issue       (ld_issue),
    .ld_rd          (ld_rd),
    .ld_issue_ready (ld_issue_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .chk_rs         (chk_rs),
    .chk_rt         (chk_rt),
    .hazard         (hazard),
    .regWrite       (regWrite),
    .rd             (rd),
    .data           (data),
    .pending_cnt    (pending_cnt),
    .wb_err         (wb_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        li;
    logic [4:0]  lrd;
    logic        mv;
    logic [31:0] mdata;
    logic [4:0]  crs;
    logic [4:0]  crt;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [2:0]  e_pend;
    logic        e_hz;
    logic        e_ar;
    logic        e_lr;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                     input logic li, input logic [4:0] lrd,
                     input logic mv, input logic [31:0] mdata,
                     input logic [4:0] crs, input logic [4:0] crt,
                     input logic e_rw, input logic [4:0] e_rd, input logic [31:0] e_data,
                     input logic [2:0] e_pend, input logic e_hz, input logic e_ar,
                     input logic e_lr, input logic e_err);
    vec_t v;
    v = '{av, ard, adata, li, lrd, mv, mdata, crs, crt,
          e_rw, e_rd, e_data, e_pend, e_hz, e_ar, e_lr, e_err};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue   = 1'b0; ld_rd  = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk_rs     = '0;   chk_rt = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    check("rst regWrite", 32'(regWrite), 0);
    check("rst rd", 32'(rd), 0);
    check("rst data", data, 0);
    check("rst pending", 32'(pending_cnt), 0);
    check("rst wb_err", 32'(wb_err), 0);
    check("rst alu_ready", 32'(alu_ready), 1);
    check("rst ld_ready", 32'(ld_issue_ready), 1);
    check("rst hazard", 32'(hazard), 0);
    reset = 1'b1;

    //  av ard adata         li lrd mv mdata       crs crt | rw rd data          pd hz ar lr er
    add(1, 5, 32'hA5A5_0001, 0, 0,  0, 0,            0, 0,   1, 5, 32'hA5A5_0001, 0, 0, 1, 1, 0);
    add(0, 0, 0,             0, 0,  0, 0,            5, 0,   0, 5, 32'hA5A5_0001, 0, 0, 1, 1, 0);
    add(0, 0, 0,             1, 1,  0, 0,            1, 0,   0, 5, 32'hA5A5_0001, 1, 1, 1, 1, 0);
    add(0, 0, 0,             1, 2,  0, 0,            0, 0,   0, 5, 32'hA5A5_0001, 2, 0, 1, 1, 0);
    add(0, 0, 0,             1, 3,  0, 0,            0, 0,   0, 5, 32'hA5A5_0001, 3, 0, 1, 1, 0);
    add(0, 0, 0,             1, 4,  0, 0,            0, 0,   0, 5, 32'hA5A5_0001, 4, 0, 1, 0, 0);
    add(0, 0, 0,             1, 6,  0, 0,            0, 6,   0, 5, 32'hA5A5_0001, 4, 0, 1, 0, 0);
    add(0, 0, 0,             0, 0,  1, 32'h11,       0, 0,   1, 1, 32'h11,        3, 0, 1, 1, 0);
    add(0, 0, 0,             1, 7,  1, 32'h22,       0, 0,   1, 2, 32'h22,        3, 0, 1, 1, 0);
    add(0, 0, 0,             0, 0,  1, 32'h33,       0, 0,   1, 3, 32'h33,        2, 0, 1, 1, 0);
    add(0, 0, 0,             0, 0,  1, 32'h44,       7, 0,   1, 4, 32'h44,        1, 1, 1, 1, 0);
    add(0, 0, 0,             0, 0,  0, 0,            7, 0,   0, 4, 32'h44,        1, 1, 1, 1, 0);
    add(0, 0, 0,             0, 0,  1, 32'h77,       7, 0,   1, 7, 32'h77,        0, 1, 1, 1, 0);
    add(0, 0, 0,             0, 0,  0, 0,            7, 0,   0, 7, 32'h77,        0, 0, 1, 1, 0);
    add(0, 0, 0,             1, 0,  0, 0,            0, 0,   0, 7, 32'h77,        1, 0, 1, 1, 0);
    add(0, 0, 0,             0, 0,  1, 32'hDEAD,     0, 0,   0, 7, 32'h77,        0, 0, 1, 1, 0);
    add(0, 0, 0,             1, 8,  0, 0,            0, 0,   0, 7, 32'h77,        1, 0, 1, 1, 0);
    add(1, 9, 32'h99,        0, 0,  1, 32'h88,       0, 0,   1, 8, 32'h88,        0, 0, 0, 1, 0);
    add(0, 0, 0,             0, 0,  0, 0,            0, 0,   1, 9, 32'h99,        0, 0, 1, 1, 0);
    add(0, 0, 0,             0, 0,  0, 0,            0, 0,   0, 9, 32'h99,        0, 0, 1, 1, 0);
    add(0, 0, 0,             1, 10, 0, 0,            0, 0,   0, 9, 32'h99,        1, 0, 1, 1, 0);
    add(1, 11, 32'hBB,       0, 0,  1, 32'hAA,       0, 0,   1, 10, 32'hAA,       0, 0, 0, 1, 0);
    add(1, 12, 32'hCC,       0, 0,  0, 0,            0, 0,   1, 11, 32'hBB,       0, 0, 1, 1, 0);
    add(1, 12, 32'hCC,       0, 0,  0, 0,            0, 12,  1, 12, 32'hCC,       0, 1, 1, 1, 0);
    add(1, 0, 32'h55,        0, 0,  0, 0,            0, 0,   0, 12, 32'hCC,       0, 0, 1, 1, 0);

    @(posedge clock); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      alu_valid  = vecs[i].av;  alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
      ld_issue   = vecs[i].li;  ld_rd  = vecs[i].lrd;
      mem_rvalid = vecs[i].mv;  mem_rdata = vecs[i].mdata;
      chk_rs     = vecs[i].crs; chk_rt = vecs[i].crt;
      @(posedge clock); #1;
      check($sformatf("v%0d regWrite", i), 32'(regWrite), 32'(vecs[i].e_rw));
      check($sformatf("v%0d rd", i), 32'(rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d data", i), data, vecs[i].e_data);
      check($sformatf("v%0d pending", i), 32'(pending_cnt), 32'(vecs[i].e_pend));
      check($sformatf("v%0d hazard", i), 32'(hazard), 32'(vecs[i].e_hz));
      check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
      check($sformatf("v%0d ld_ready", i), 32'(ld_issue_ready), 32'(vecs[i].e_lr));
      check($sformatf("v%0d wb_err", i), 32'(wb_err), 32'(vecs[i].e_err));
    end

    // Asynchronous reset with two loads outstanding and a write in flight.
    idle_inputs();
    ld_issue = 1'b1; ld_rd = 5'd3;
    @(posedge clock); #1;
    ld_rd = 5'd4; alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h1234; chk_rs = 5'd3;
    @(posedge clock); #1;
    ld_issue = 1'b0; alu_valid = 1'b0;
    check("pre-rst pending", 32'(pending_cnt), 2);
    check("pre-rst regWrite", 32'(regWrite), 1);
    check("pre-rst hazard", 32'(hazard), 1);
    #2 reset = 1'b0;
    #1;
    check("async rst pending", 32'(pending_cnt), 0);
    check("async rst regWrite", 32'(regWrite), 0);
    check("async rst hazard", 32'(hazard), 0);
    check("async rst rd", 32'(rd), 0);
    check("async rst ld_ready", 32'(ld_issue_ready), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    check("orphan rvalid wb_err", 32'(wb_err), 1);
    check("orphan rvalid regWrite", 32'(regWrite), 0);
    check("orphan rvalid pending", 32'(pending_cnt), 0);
    @(posedge clock); #1;
    check("wb_err sticky", 32'(wb_err), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
